throw_sequencer: RTL

//  Game-level controller for the aim/launch datapath. Generates the frame-rate
//  'update' tick and debounces the fire button. Gates the active-low aim buttons
//  so angle/power change only while aiming. Latches Vel/Ang at fire and hands

---
 rtl/throw_sequencer_pkg.sv | 33 +++
 rtl/throw_sequencer_btn_debounce.sv | 51 +++++
 rtl/throw_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/throw_sequencer_pkg.sv
// Shared definitions for the throw sequencer: state encoding, button level, tick default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package throw_sequencer_pkg;

  // Three-bit state encoding for the game FSM.
  localparam logic [2:0] ST_ENC_AIM    = 3'd0;
  localparam logic [2:0] ST_ENC_LAUNCH = 3'd1;
  localparam logic [2:0] ST_ENC_FLIGHT = 3'd2;
  localparam logic [2:0] ST_ENC_RESULT = 3'd3;
  localparam logic [2:0] ST_ENC_OVER   = 3'd4;

  typedef enum logic [2:0] {
    S_AIM    = ST_ENC_AIM,
    S_LAUNCH = ST_ENC_LAUNCH,
    S_FLIGHT = ST_ENC_FLIGHT,
    S_RESULT = ST_ENC_RESULT,
    S_OVER   = ST_ENC_OVER
  } state_t;

  // Buttons are active-low: a pressed button reads 0.
  localparam logic BTN_ACTIVE = 1'b0;

  // 60 Hz update tick from a 50 MHz clock.
  localparam int DEFAULT_TICK_DIV = 833333;

  // Increment a 4-bit counter, holding at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic en);
    if (en && (v != 4'hF)) return v + 4'd1;
    return v;
  endfunction

endpackage

// File: rtl/throw_sequencer_btn_debounce.sv
// Button conditioner: 2-flop sync, tick-sampled 2-sample filter, 1-clk press-edge pulse.
// Latency: 2 clks sync, then press reported on the 2nd consecutive low sample tick (+1 clk).
// Backpressure: none; a press not consumed in its pulse clk is lost.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_btn_n    : raw asynchronous button, active-low
//   i_sample   : 1-clk sample strobe (update tick)
//   o_press    : 1-clk pulse on the rising edge of the filtered 'pressed' level
module throw_sequencer_btn_debounce
  import throw_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  input  logic i_sample,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_samp_low;   // previous tick sample was 'pressed'
  logic r_pressed;
  logic r_pressed_d;
  logic w_low;

  assign w_low = (r_sync2 == BTN_ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= ~BTN_ACTIVE;
      r_sync2     <= ~BTN_ACTIVE;
      r_samp_low  <= 1'b0;
      r_pressed   <= 1'b0;
      r_pressed_d <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      // Pressed only after two consecutive low samples; any high sample releases.
      if (i_sample) begin
        r_samp_low <= w_low;
        r_pressed  <= w_low & r_samp_low;
      end
      r_pressed_d <= r_pressed;
    end
  end

  // Edge of the filtered level: holding the button never re-triggers.
  assign o_press = r_pressed & ~r_pressed_d;

endmodule

// File: rtl/throw_sequencer.sv
// Game controller: update tick, aim-button gating, fire debounce, launch handshake, scoring.
// Latency: fire press -> launch pulse 1 clk later; ball_done -> counters updated next clk.
// Backpressure: none; presses outside AIM and ball_done outside FLIGHT are dropped.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   angleup_n/angledown_n/
//   powerup_n/powerdown_n/fire_n  : raw active-low buttons
//   Vel[2:0], Ang[4:0]            : current aim values, latched at fire
//   ball_done, ball_hit           : trajectory engine completion (hit valid with done)
//   update                        : 1-clk pulse every TICK_DIV clks
//   aim_*                         : synced aim buttons, forced released outside AIM
//   launch, launch_vel, launch_ang: start pulse and latched launch parameters
//   busy, throws, hits, game_over : game status
module throw_sequencer
  import throw_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int MAX_THROWS   = 10,
  parameter int FLIGHT_TICKS = 600,
  parameter int RESULT_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       angleup_n,
  input  logic       angledown_n,
  input  logic       powerup_n,
  input  logic       powerdown_n,
  input  logic       fire_n,
  input  logic [2:0] Vel,
  input  logic [4:0] Ang,
  input  logic       ball_done,
  input  logic       ball_hit,
  output logic       update,
  output logic       aim_angleup,
  output logic       aim_angledown,
  output logic       aim_powerup,
  output logic       aim_powerdown,
  output logic       launch,
  output logic [2:0] launch_vel,
  output logic [4:0] launch_ang,
  output logic       busy,
  output logic [3:0] throws,
  output logic [3:0] hits,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // ---------------- update tick ----------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  assign update = w_tick;

  // ---------------- aim button sync ----------------
  // Bit order: {angleup, angledown, powerup, powerdown}.
  logic [3:0] r_aim_s1;
  logic [3:0] r_aim_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aim_s1 <= {4{~BTN_ACTIVE}};
      r_aim_s2 <= {4{~BTN_ACTIVE}};
    end else begin
      r_aim_s1 <= {angleup_n, angledown_n, powerup_n, powerdown_n};
      r_aim_s2 <= r_aim_s1;
    end
  end

  // ---------------- fire debounce ----------------
  logic w_fire_press;

  throw_sequencer_btn_debounce u_fire_db (
    .clk      (clk),
    .rst      (rst),
    .i_btn_n  (fire_n),
    .i_sample (w_tick),
    .o_press  (w_fire_press)
  );

  // ---------------- FSM ----------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_flight_cnt;
  logic [7:0] r_result_cnt;
  logic [3:0] r_throws;
  logic [3:0] r_hits;
  logic [2:0] r_vel;
  logic [4:0] r_ang;

  logic w_latch;
  logic w_enter_result;
  logic w_hit;
  logic w_flight_to;
  logic w_result_done;
  logic w_launch;
  logic w_busy;
  logic w_over;
  logic w_aim_en;

  assign w_flight_to   = (r_flight_cnt == 10'(FLIGHT_TICKS));
  assign w_result_done = (r_result_cnt == 8'(RESULT_TICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_AIM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    w_enter_result = 1'b0;
    w_hit          = 1'b0;
    w_launch       = 1'b0;
    w_busy         = 1'b0;
    w_over         = 1'b0;
    w_aim_en       = 1'b0;
    case (r_state)
      S_AIM: begin
        w_aim_en = 1'b1;
        if (w_fire_press) begin
          w_state_nxt = S_LAUNCH;
          w_latch     = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_launch    = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_FLIGHT;
      end
      S_FLIGHT: begin
        w_busy = 1'b1;
        // A landing reported in the timeout clk still scores.
        if (ball_done) begin
          w_state_nxt    = S_RESULT;
          w_enter_result = 1'b1;
          w_hit          = ball_hit;
        end else if (w_flight_to) begin
          w_state_nxt    = S_RESULT;
          w_enter_result = 1'b1;
        end
      end
      S_RESULT: begin
        w_busy = 1'b1;
        if (w_result_done) begin
          w_state_nxt = (r_throws == 4'(MAX_THROWS)) ? S_OVER : S_AIM;
        end
      end
      S_OVER: begin
        w_over = 1'b1;
      end
      default: begin
        w_state_nxt = S_AIM;
      end
    endcase
  end

  // ---------------- counters and latches ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flight_cnt <= '0;
      r_result_cnt <= '0;
      r_throws     <= '0;
      r_hits       <= '0;
      r_vel        <= '0;
      r_ang        <= '0;
    end else begin
      if (w_latch) begin
        r_vel <= Vel;
        r_ang <= Ang;
      end

      if (r_state == S_LAUNCH)
        r_flight_cnt <= '0;
      else if ((r_state == S_FLIGHT) && w_tick && !w_flight_to)
        r_flight_cnt <= r_flight_cnt + 10'd1;

      // Scoring happens only on the single transition clk into RESULT.
      if (w_enter_result) begin
        r_result_cnt <= '0;
        r_throws     <= sat_inc4(r_throws, 1'b1);
        r_hits       <= sat_inc4(r_hits, w_hit);
      end else if ((r_state == S_RESULT) && w_tick && !w_result_done) begin
        r_result_cnt <= r_result_cnt + 8'd1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign aim_angleup   = w_aim_en ? r_aim_s2[3] : ~BTN_ACTIVE;
  assign aim_angledown = w_aim_en ? r_aim_s2[2] : ~BTN_ACTIVE;
  assign aim_powerup   = w_aim_en ? r_aim_s2[1] : ~BTN_ACTIVE;
  assign aim_powerdown = w_aim_en ? r_aim_s2[0] : ~BTN_ACTIVE;

  assign launch     = w_launch;
  assign launch_vel = r_vel;
  assign launch_ang = r_ang;
  assign busy       = w_busy;
  assign throws     = r_throws;
  assign hits       = r_hits;
  assign game_over  = w_over;

endmodule
